// File: rtl/drug_pump_if.sv
// Command and status bundle between the monitor side and the infusion pump controller.
interface drug_pump_if;
  logic        drug_delivery_activate;
  logic [7:0]  drug_dosage;
  logic        pump_enable;
  logic        pump_step;
  logic        valve_drug;
  logic        valve_saline;
  logic        busy;
  logic        dose_done;
  logic        aborted;
  logic        overrun;
  logic [15:0] steps_delivered;

  modport master (
    output drug_delivery_activate, drug_dosage,
    input  pump_enable, pump_step, valve_drug, valve_saline, busy,
           dose_done, aborted, overrun, steps_delivered
  );

  modport slave (
    input  drug_delivery_activate, drug_dosage,
    output pump_enable, pump_step, valve_drug, valve_saline, busy,
           dose_done, aborted, overrun, steps_delivered
  );
endinterface

// File: rtl/drug_pump_controller.sv
// Turns level-style dosage commands into valve selection plus a metered pump step train,
// with a one-deep pending slot, abort on activate drop and a sticky overrun flag.
module drug_pump_controller #(
  parameter int STEPS_PER_UNIT = 4,
  parameter int STEP_DIV       = 8,
  parameter int PRIME_CYCLES   = 4,
  parameter int SALINE_CODE    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  drug_pump_if.slave pif
);
  localparam int PW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
  localparam int DW = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(STEP_DIV - 1);
  localparam logic [7:0]    SALINE     = 8'(SALINE_CODE);
  localparam logic [15:0]   SPU        = 16'(STEPS_PER_UNIT);

  typedef enum logic [1:0] {IDLE, PRIME, PUMP, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    prev_q, prev_d;
  logic [15:0]   target_q, target_d;
  logic [15:0]   steps_q, steps_d;
  logic [15:0]   pend_target_q, pend_target_d;
  logic          line_q, line_d;
  logic          pend_line_q, pend_line_d;
  logic          pend_vld_q, pend_vld_d;
  logic [PW-1:0] prime_q, prime_d;
  logic [DW-1:0] div_q, div_d;
  logic          overrun_q, overrun_d;
  logic          pump_enable_q, pump_enable_d;
  logic          pump_step_q, pump_step_d;
  logic          valve_drug_q, valve_drug_d;
  logic          valve_saline_q, valve_saline_d;
  logic          busy_q, busy_d;
  logic          dose_done_q, dose_done_d;
  logic          aborted_q, abort;

  logic        act, new_cmd, cmd_line;
  logic [15:0] cmd_target;

  assign act        = pif.drug_delivery_activate;
  assign new_cmd    = act && (pif.drug_dosage != 8'd0) && (pif.drug_dosage != prev_q);
  assign cmd_target = 16'(pif.drug_dosage) * SPU;
  assign cmd_line   = (pif.drug_dosage == SALINE);

  always_comb begin
    state_d       = state_q;
    prev_d        = act ? pif.drug_dosage : 8'd0;
    target_d      = target_q;
    line_d        = line_q;
    steps_d       = steps_q;
    prime_d       = prime_q;
    div_d         = div_q;
    pend_vld_d    = pend_vld_q;
    pend_target_d = pend_target_q;
    pend_line_d   = pend_line_q;
    overrun_d     = overrun_q;
    abort         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A fresh command is served ahead of the pending slot, which then stays queued.
        if (new_cmd || pend_vld_q) begin
          target_d = new_cmd ? cmd_target : pend_target_q;
          line_d   = new_cmd ? cmd_line : pend_line_q;
          if (!new_cmd) pend_vld_d = 1'b0;
          prime_d  = '0;
          steps_d  = '0;
          state_d  = PRIME;
        end
      end
      PRIME: begin
        if (!act) begin
          abort = 1'b1;
        end else if (prime_q == PRIME_LAST) begin
          div_d   = '0;
          state_d = PUMP;
        end else begin
          prime_d = prime_q + PW'(1);
        end
      end
      PUMP: begin
        // A step already on the wire is counted even if this cycle aborts.
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          steps_d = steps_q + 16'd1;
          if (steps_d == target_q) state_d = DONE;
        end else begin
          div_d = div_q + DW'(1);
        end
        if (!act) abort = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      pend_vld_d = 1'b0;
    end else if (new_cmd && (state_q != IDLE)) begin
      if (!pend_vld_q) begin
        pend_vld_d    = 1'b1;
        pend_target_d = cmd_target;
        pend_line_d   = cmd_line;
      end else begin
        overrun_d = 1'b1;
      end
    end

    pump_enable_d  = (state_d == PRIME) || (state_d == PUMP);
    valve_drug_d   = pump_enable_d && !line_d;
    valve_saline_d = pump_enable_d && line_d;
    pump_step_d    = (state_d == PUMP) && (div_d == DIV_LAST);
    busy_d         = (state_d != IDLE);
    dose_done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      prev_q         <= '0;
      target_q       <= '0;
      steps_q        <= '0;
      pend_target_q  <= '0;
      line_q         <= 1'b0;
      pend_line_q    <= 1'b0;
      pend_vld_q     <= 1'b0;
      prime_q        <= '0;
      div_q          <= '0;
      overrun_q      <= 1'b0;
      pump_enable_q  <= 1'b0;
      pump_step_q    <= 1'b0;
      valve_drug_q   <= 1'b0;
      valve_saline_q <= 1'b0;
      busy_q         <= 1'b0;
      dose_done_q    <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      target_q       <= target_d;
      steps_q        <= steps_d;
      pend_target_q  <= pend_target_d;
      line_q         <= line_d;
      pend_line_q    <= pend_line_d;
      pend_vld_q     <= pend_vld_d;
      prime_q        <= prime_d;
      div_q          <= div_d;
      overrun_q      <= overrun_d;
      pump_enable_q  <= pump_enable_d;
      pump_step_q    <= pump_step_d;
      valve_drug_q   <= valve_drug_d;
      valve_saline_q <= valve_saline_d;
      busy_q         <= busy_d;
      dose_done_q    <= dose_done_d;
      aborted_q      <= abort;
    end
  end

  assign pif.pump_enable     = pump_enable_q;
  assign pif.pump_step       = pump_step_q;
  assign pif.valve_drug      = valve_drug_q;
  assign pif.valve_saline    = valve_saline_q;
  assign pif.busy            = busy_q;
  assign pif.dose_done       = dose_done_q;
  assign pif.aborted         = aborted_q;
  assign pif.overrun         = overrun_q;
  assign pif.steps_delivered = steps_q;
endmodule

// File: doc/drug_pump_controller.md
Name: drug_pump_controller

Overview:
- Actuator-side counterpart of the heart monitor's drug-delivery interface. It consumes the level-style `drug_delivery_activate` / `drug_dosage` command pair and turns each new non-zero dosage into a valve selection plus a metered train of pump step pulses.
- It holds one pending command, reports completion, abort and overrun, and sits between the monitoring logic and the infusion pump / valve drivers.

Parameters:
- STEPS_PER_UNIT, 4: pump steps per dosage unit (mg or mL).
- STEP_DIV, 8: clock cycles per pump step; minimum 2.
- PRIME_CYCLES, 4: valve settling cycles before pumping starts; minimum 1.
- SALINE_CODE, 20: dosage value that selects the saline line. Every other non-zero value selects the drug line.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- drug_delivery_activate  in  1  delivery enable from the monitor.
- drug_dosage  in  8  requested dose, in units.
- pump_enable  out  1  high in PRIME and PUMP.
- pump_step  out  1  one-cycle step pulse.
- valve_drug  out  1  drug line open.
- valve_saline  out  1  saline line open.
- busy  out  1  state != IDLE.
- dose_done  out  1  one-cycle pulse when a dose completes.
- aborted  out  1  one-cycle pulse when a dose is aborted.
- overrun  out  1  sticky flag: a command was dropped.
- steps_delivered  out  16  steps issued for the current or last dose.

Behaviour:
- Reset (async, rst_n=0): every output is 0. State=IDLE; pending, prev_dosage and all counters are cleared. Reset asserted mid-operation closes the valves immediately.
- Command detect:
  - prev_dosage <= activate ? drug_dosage : 0, registered every cycle.
  - new_cmd = activate & (drug_dosage != 0) & (drug_dosage != prev_dosage).
  - Consequence: a held dosage value is one command, and re-raising activate with the same value is a new command.
- Dose latch: target = drug_dosage * STEPS_PER_UNIT, 16-bit, no overflow (max 255*STEPS_PER_UNIT must fit). line_saline = (drug_dosage == SALINE_CODE).
- States are IDLE, PRIME, PUMP and DONE.
- IDLE:
  - On new_cmd, latch the dose and go to PRIME on the next edge.
  - Else, if pending is valid, load pending, clear it, and go to PRIME.
- PRIME:
  - valve_saline = line_saline and valve_drug = ~line_saline; both valves are never high together.
  - steps_delivered is cleared on entry.
  - Stay PRIME_CYCLES cycles, then go to PUMP.
- PUMP:
  - Valve outputs are held as in PRIME.
  - div_cnt counts 0..STEP_DIV-1. pump_step=1 and steps_delivered increments in the cycle div_cnt==STEP_DIV-1.
  - Go to DONE in the cycle after the step that makes steps_delivered == target. Total PUMP time is target*STEP_DIV cycles.
- DONE (1 cycle): dose_done=1, valves closed, pump_enable=0, steps_delivered holds. Then go to IDLE; IDLE serves pending the following cycle.
- Command while busy (PRIME, PUMP or DONE):
  - If pending is empty, store the command in pending.
  - If pending is full, drop the new command and set overrun=1. overrun clears only on reset.
- Abort: activate=0 while in PRIME or PUMP → aborted=1 for one cycle, pending cleared, and IDLE on the next edge. Valves and pump_enable drop on that edge, and steps_delivered holds the partial count.
- activate=0 in IDLE or DONE has no effect except clearing prev_dosage. A DONE cycle still produces dose_done.
- Simultaneous new_cmd and abort condition: abort wins and the command is discarded.
- Outputs are registered with no combinational input-to-output paths. Command-to-valve latency is 1 cycle.

Test Plan:
- Base configuration for all scenarios: defaults (STEPS_PER_UNIT=4, STEP_DIV=8, PRIME_CYCLES=4).
- Single drug dose: activate=1, dosage 0→6.
  - valve_drug rises 1 cycle later and pumping starts after 4 prime cycles.
  - 24 pump_step pulses, each 8 cycles apart; steps_delivered=24.
  - dose_done pulses once, then busy=0 and valve_drug=0.
- Saline line: dosage=20 → valve_saline=1, valve_drug=0, 80 steps, dose_done.
  - Holding dosage=20 afterwards issues no second dose.
- Queued command: dosage 6, switching to 20 during PUMP.
  - The 6 dose completes with 24 steps.
  - One IDLE cycle follows, then PRIME with the saline valve and 80 steps.
  - overrun stays 0.
- Overrun: while 6 is pumping, apply 20 then 12, each held ≥2 cycles.
  - 12 is dropped and overrun=1.
  - Only 24 and 80 steps are issued, and overrun stays 1 until reset.
- Abort and reset:
  - activate→0 after 10 steps: aborted pulses, valves close next edge, steps_delivered=10, no dose_done, pending cleared.
  - Separately, rst_n=0 mid-PUMP: all outputs 0 immediately (asynchronous), state IDLE.
